// File: rtl/twin_stick_pkg.sv
// ---------------------------------------------------------------------------
// twin_stick_pkg : shared axis-state enum, direction indices and defaults
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package twin_stick_pkg;

  typedef enum logic [1:0] {
    AXIS_NEUTRAL = 2'd0,
    AXIS_POS     = 2'd1,
    AXIS_NEG     = 2'd2
  } axis_state_t;

  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;

  localparam int AXIS_LX = 0;
  localparam int AXIS_LY = 1;
  localparam int AXIS_RX = 2;
  localparam int AXIS_RY = 3;

  localparam int DEAD_IN_DEFAULT  = 48;
  localparam int DEAD_OUT_DEFAULT = 32;
  localparam int HOLD_DEFAULT     = 2;
  localparam int TICK_DIV_DEFAULT = 12000;

  function automatic logic [3:0] dirs_from_axes(input axis_state_t x, input axis_state_t y);
    logic [3:0] d;
    d            = 4'b0000;
    d[DIR_RIGHT] = (x == AXIS_POS);
    d[DIR_LEFT]  = (x == AXIS_NEG);
    d[DIR_DOWN]  = (y == AXIS_POS);
    d[DIR_UP]    = (y == AXIS_NEG);
    return d;
  endfunction

  // Simultaneous opposing directions resolve to neutral on that axis.
  function automatic logic [3:0] socd_neutral(input logic [3:0] raw);
    logic [3:0] d;
    d = raw;
    if (raw[DIR_UP] && raw[DIR_DOWN]) begin
      d[DIR_UP]   = 1'b0;
      d[DIR_DOWN] = 1'b0;
    end
    if (raw[DIR_LEFT] && raw[DIR_RIGHT]) begin
      d[DIR_LEFT]  = 1'b0;
      d[DIR_RIGHT] = 1'b0;
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/twin_stick_decoder_axis_hyst.sv
// ---------------------------------------------------------------------------
// axis_hyst : per-axis hysteresis FSM with tick-based persistence filter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_hyst
  import twin_stick_pkg::*;
#(
  parameter int DEAD_IN  = DEAD_IN_DEFAULT,
  parameter int DEAD_OUT = DEAD_OUT_DEFAULT,
  parameter int HOLD     = HOLD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [7:0]  value,
  output axis_state_t state
);

  localparam logic signed [9:0] IN_P  = 10'(DEAD_IN);
  localparam logic signed [9:0] IN_N  = -10'(DEAD_IN);
  localparam logic signed [9:0] OUT_P = 10'(DEAD_OUT);
  localparam logic signed [9:0] OUT_N = -10'(DEAD_OUT);

  logic [7:0]        sat;
  logic signed [9:0] v;
  axis_state_t       cand;
  axis_state_t       pend;
  logic [3:0]        hold_cnt;
  logic [3:0]        next_cnt;

  assign sat = (value == 8'h80) ? 8'h81 : value;
  assign v   = {{2{sat[7]}}, sat};

  always_comb begin
    cand = state;
    case (state)
      AXIS_NEUTRAL: begin
        if (v >= IN_P)      cand = AXIS_POS;
        else if (v <= IN_N) cand = AXIS_NEG;
      end
      AXIS_POS: begin
        if (v <= IN_N)       cand = AXIS_NEG;
        else if (v < OUT_P)  cand = AXIS_NEUTRAL;
      end
      AXIS_NEG: begin
        if (v >= IN_P)       cand = AXIS_POS;
        else if (v > OUT_N)  cand = AXIS_NEUTRAL;
      end
      default: cand = AXIS_NEUTRAL;
    endcase
  end

  // A streak only continues while the same non-current candidate repeats.
  assign next_cnt = (cand == pend && hold_cnt != 4'd0) ? hold_cnt + 4'd1 : 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= AXIS_NEUTRAL;
      pend     <= AXIS_NEUTRAL;
      hold_cnt <= 4'd0;
    end else if (tick) begin
      if (cand == state) begin
        hold_cnt <= 4'd0;
      end else if (next_cnt == 4'(HOLD)) begin
        state    <= cand;
        hold_cnt <= 4'd0;
      end else begin
        pend     <= cand;
        hold_cnt <= next_cnt;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/twin_stick_decoder.sv
// ---------------------------------------------------------------------------
// twin_stick_decoder : digital/dual-analog stick to run/aim direction bits
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module twin_stick_decoder
  import twin_stick_pkg::*;
#(
  parameter int DEAD_IN  = DEAD_IN_DEFAULT,
  parameter int DEAD_OUT = DEAD_OUT_DEFAULT,
  parameter int HOLD     = HOLD_DEFAULT,
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic        clock_12,
  input  logic        reset,
  input  logic        mode,
  input  logic [3:0]  joy_dig,
  input  logic [15:0] joy_l,
  input  logic [15:0] joy_r,
  output logic [3:0]  run,
  output logic [3:0]  aim
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [7:0]       axis_val [4];
  axis_state_t      axis_st  [4];
  logic [3:0]       dig_clean;
  logic [3:0]       run_next;
  logic [3:0]       aim_next;

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign axis_val[AXIS_LX] = joy_l[7:0];
  assign axis_val[AXIS_LY] = joy_l[15:8];
  assign axis_val[AXIS_RX] = joy_r[7:0];
  assign axis_val[AXIS_RY] = joy_r[15:8];

  generate
    for (genvar i = 0; i < 4; i++) begin : g_axis
      axis_hyst #(
        .DEAD_IN  (DEAD_IN),
        .DEAD_OUT (DEAD_OUT),
        .HOLD     (HOLD)
      ) u_axis_hyst (
        .clk   (clock_12),
        .rst   (reset),
        .tick  (tick),
        .value (axis_val[i]),
        .state (axis_st[i])
      );
    end
  endgenerate

  assign dig_clean = socd_neutral(joy_dig);

  always_comb begin
    run_next = dig_clean;
    aim_next = dig_clean;
    if (mode) begin
      run_next = dirs_from_axes(axis_st[AXIS_LX], axis_st[AXIS_LY]);
      aim_next = dirs_from_axes(axis_st[AXIS_RX], axis_st[AXIS_RY]);
    end
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      run <= 4'b0000;
      aim <= 4'b0000;
    end else begin
      run <= run_next;
      aim <= aim_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_twin_stick_decoder.sv
// ---------------------------------------------------------------------------
// tb_twin_stick_decoder : scoreboard bench with a behavioural stick model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_twin_stick_decoder;

  localparam int T_DEAD_IN  = 48;
  localparam int T_DEAD_OUT = 32;
  localparam int T_HOLD     = 2;
  localparam int T_DIV      = 8;

  logic        clock_12 = 1'b0;
  logic        reset    = 1'b1;
  logic        mode     = 1'b0;
  logic [3:0]  joy_dig  = 4'b0000;
  logic [15:0] joy_l    = 16'h0000;
  logic [15:0] joy_r    = 16'h0000;
  logic [3:0]  run;
  logic [3:0]  aim;

  int n_checks = 0;
  int n_fail   = 0;

  twin_stick_decoder #(
    .DEAD_IN  (T_DEAD_IN),
    .DEAD_OUT (T_DEAD_OUT),
    .HOLD     (T_HOLD),
    .TICK_DIV (T_DIV)
  ) dut (
    .clock_12 (clock_12),
    .reset    (reset),
    .mode     (mode),
    .joy_dig  (joy_dig),
    .joy_l    (joy_l),
    .joy_r    (joy_r),
    .run      (run),
    .aim      (aim)
  );

  always #5 clock_12 = ~clock_12;

  // Reference model: axis direction as -1/0/+1, plus a streak of identical candidates.
  int          m_dir    [4];
  int          m_streak [4];
  int          m_last   [4];
  int          m_cycles;
  logic [7:0]  exp_q [$];

  function automatic int want(input int cur, input int raw);
    int v;
    v = (raw == -128) ? -127 : raw;
    if (cur == 0)  return (v >= T_DEAD_IN) ? 1 : (v <= -T_DEAD_IN) ? -1 : 0;
    if (cur == 1)  return (v <= -T_DEAD_IN) ? -1 : (v < T_DEAD_OUT) ? 0 : 1;
    return (v >= T_DEAD_IN) ? 1 : (v > -T_DEAD_OUT) ? 0 : -1;
  endfunction

  function automatic logic [3:0] pack_dirs(input int x, input int y);
    return {y == -1, y == 1, x == -1, x == 1};
  endfunction

  function automatic logic [3:0] dig_model(input logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (d[3] && d[2]) r[3:2] = 2'b00;
    if (d[1] && d[0]) r[1:0] = 2'b00;
    return r;
  endfunction

  always @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_dir[i] = 0; m_streak[i] = 0; m_last[i] = 0;
      end
      m_cycles = 0;
      exp_q.delete();
    end else begin
      int raw [4];
      int c;
      raw[0] = int'($signed(joy_l[7:0]));
      raw[1] = int'($signed(joy_l[15:8]));
      raw[2] = int'($signed(joy_r[7:0]));
      raw[3] = int'($signed(joy_r[15:8]));
      if (mode) exp_q.push_back({pack_dirs(m_dir[0], m_dir[1]), pack_dirs(m_dir[2], m_dir[3])});
      else      exp_q.push_back({dig_model(joy_dig), dig_model(joy_dig)});
      if ((m_cycles % T_DIV) == T_DIV - 1) begin
        for (int i = 0; i < 4; i++) begin
          c = want(m_dir[i], raw[i]);
          if (c == m_dir[i]) m_streak[i] = 0;
          else if (m_streak[i] > 0 && c == m_last[i]) m_streak[i]++;
          else begin m_streak[i] = 1; m_last[i] = c; end
          if (m_streak[i] >= T_HOLD) begin m_dir[i] = c; m_streak[i] = 0; end
        end
      end
      m_cycles++;
    end
  end

  always @(negedge clock_12) begin
    logic [7:0] e;
    if (reset) begin
      n_checks++;
      if (run !== 4'b0000 || aim !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs: run=%b aim=%b required 0000/0000 at %0t", run, aim, $time);
      end
    end else if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_underflow: no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if ({run, aim} !== e) begin
        n_fail++;
        $display("FAIL outputs: run=%b aim=%b required run=%b aim=%b at %0t",
                 run, aim, e[7:4], e[3:0], $time);
      end
      n_checks++;
      if ((run[3] && run[2]) || (run[1] && run[0]) || (aim[3] && aim[2]) || (aim[1] && aim[0])) begin
        n_fail++;
        $display("FAIL opposing_bits: run=%b aim=%b required no opposing pair at %0t", run, aim, $time);
      end
    end
  end

  task automatic step();
    @(posedge clock_12); #2;
  endtask

  task automatic ticks(input int n);
    repeat (n * T_DIV) step();
  endtask

  task automatic release_reset();
    @(negedge clock_12); #2 reset = 1'b0;
  endtask

  task automatic pulse_reset(input int hold_clocks);
    step(); reset = 1'b1;
    repeat (hold_clocks) step();
    release_reset();
  endtask

  function automatic logic [15:0] stick(input int x, input int y);
    return {8'(y), 8'(x)};
  endfunction

  function automatic int pick_val();
    int tbl [14] = '{0, 31, 32, 33, 40, 47, 48, 60, 127, -128, -31, -32, -48, -60};
    if ($urandom_range(0, 3) == 0) return int'($signed(8'($urandom)));
    return tbl[$urandom_range(0, 13)];
  endfunction

  initial begin
    repeat (3) step();
    release_reset();

    // Analog engage / hysteresis / direct reversal on left X
    step(); mode = 1'b1;
    joy_l = stick(60, 0);  ticks(1); ticks(1); ticks(1);
    joy_l = stick(40, 0);  ticks(3);
    joy_l = stick(31, 0);  ticks(3);
    joy_l = stick(60, 0);  ticks(3);
    joy_l = stick(-60, 0); ticks(3);

    // Right Y saturating value; left Y just inside the engage threshold
    joy_r = stick(0, -128); joy_l = stick(-60, 47); ticks(3);

    // Digital mode with SOCD resolution, then back to analog without FSM reset
    mode = 1'b0;
    joy_dig = 4'b0011; step(); step();
    joy_dig = 4'b1001; step(); step();
    joy_dig = 4'b1100; step(); step();
    mode = 1'b1; step(); step();

    // Reset mid-persistence
    pulse_reset(2);
    joy_l = stick(0, 0); joy_r = stick(0, 0); ticks(2);
    joy_l = stick(60, 0); ticks(1);
    pulse_reset(3);
    ticks(3);

    // Randomised sweep of modes, digital inputs and near-threshold axis values
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      joy_dig = 4'($urandom);
      joy_l = stick(pick_val(), pick_val());
      joy_r = stick(pick_val(), pick_val());
      if ($urandom_range(0, 40) == 0) pulse_reset($urandom_range(1, 4));
      repeat ($urandom_range(1, 3 * T_DIV)) step();
    end

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/twin_stick_decoder.md
TWIN_STICK_DECODER -- requirements
Module: twin_stick_decoder

Interface
REQ-001 SHALL have parameter DEAD_IN, default 48: engage threshold, magnitude of signed 8-bit axis.
REQ-002 SHALL have parameter DEAD_OUT, default 32: release threshold; DEAD_OUT < DEAD_IN is required.
REQ-003 SHALL have parameter HOLD, default 2: consecutive sample ticks needed to commit an axis change; range 1..15.
REQ-004 SHALL have parameter TICK_DIV, default 12000: clocks per sample tick (1 kHz at 12 MHz).
REQ-005 SHALL have port clock_12  in  1  system clock; the block uses one clock only.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port mode  in  1  0 = single digital stick drives run and aim; 1 = dual analog.
REQ-008 SHALL have port joy_dig  in  4  digital directions: [0] right, [1] left, [2] down, [3] up.
REQ-009 SHALL have port joy_l  in  16  left stick: [7:0] X signed (+ = right), [15:8] Y signed (+ = down).
REQ-010 SHALL have port joy_r  in  16  right stick, same format as joy_l.
REQ-011 SHALL have port run  out  4  {up,down,left,right} to the game input port.
REQ-012 SHALL have port aim  out  4  {up,down,left,right} to the game input port.

Function
REQ-013 SHALL count 0..TICK_DIV-1 and wrap; the tick SHALL be 1 for one clock when the count equals TICK_DIV-1.
REQ-014 SHALL run one hysteresis FSM per analog axis: LX, LY, RX, RY; each FSM has states NEUTRAL, POS and NEG.
REQ-015 SHALL evaluate each FSM only on tick, using the axis value present on that clock.
REQ-016 SHALL treat -128 as -127 (saturate) before any comparison.
REQ-017 SHALL define the candidate state as follows:
- from NEUTRAL: POS if v >= DEAD_IN; NEG if v <= -DEAD_IN; otherwise stay.
- from POS: NEG if v <= -DEAD_IN; NEUTRAL if v < DEAD_OUT; otherwise stay.
- from NEG: mirror of POS.
REQ-018 SHALL commit a candidate only after it equals the same non-current state on HOLD consecutive ticks; any other result on a tick SHALL clear the persistence counter.
REQ-019 SHALL clear the persistence counter on the tick on which a commit occurs.
REQ-020 SHALL map axis states to directions: X POS = right, X NEG = left, Y POS = down, Y NEG = up.
REQ-021 SHALL, in mode 1, take run from the LX/LY states and aim from the RX/RY states; joy_dig SHALL be ignored.
REQ-022 SHALL, in mode 0, drive run and aim both from the filtered joy_dig; analog inputs SHALL be ignored for the outputs.
REQ-023 SHALL clear both opposing bits when up+down or left+right are asserted together on joy_dig (SOCD neutral).
REQ-024 SHALL register run and aim outputs: digital path latency is 1 clock; analog path changes 1 clock after the committing tick.
REQ-025 SHALL keep the FSMs running in both modes; a mode change SHALL affect the outputs on the next clock, with no FSM reset.
REQ-026 SHALL never assert opposing bits on run or aim.

Reset
REQ-027 SHALL, while reset is high, force run = 0 and aim = 0, all FSMs to NEUTRAL, all persistence counters to 0 and the tick counter to 0.
REQ-028 SHALL produce the first tick TICK_DIV clocks after reset is released.
REQ-029 SHALL, on reset asserted mid-persistence, discard the pending commit; no output change SHALL follow the release.

Structure
REQ-030 SHALL place the axis-state enum, the direction bit indices and the default threshold constants in a shared package, twin_stick_pkg.
REQ-031 SHALL implement one sub-module, axis_hyst (FSM plus persistence counter), instantiated four times.

Verification
REQ-032 SHALL verify: mode 1, joy_l X = 60 held for 2 ticks -> run = 0001 one clock after the second tick; no change after 1 tick.
REQ-033 SHALL verify: X driven 60 to 40 -> run stays 0001; then X = 31 held for 2 ticks -> run = 0000.
REQ-034 SHALL verify: X steps 60 to -60 while POS -> NEG commits after 2 ticks, run goes 0001 to 0010, with no NEUTRAL output in between.
REQ-035 SHALL verify: joy_r Y = -128 for 2 ticks -> aim = 1000; joy_l Y = 47 -> run unchanged.
REQ-036 SHALL verify: mode 0, joy_dig = 0011 -> run = aim = 0000; joy_dig = 1001 -> run = aim = 1001 after 1 clock.
REQ-037 SHALL verify: reset asserted after 1 of 2 qualifying ticks, then released with X held at 60 -> run = 0000 until 2 further ticks have elapsed.
